// File: rtl/phaser_in_pkg.sv
// Shared encodings, widths and helpers for the input-side DDR phaser core.
package phaser_in_pkg;

  localparam int unsigned TAP_W           = 6;
  localparam int unsigned CNT_W           = 6;
  localparam int unsigned DIV_CNT_W       = 4;
  localparam int unsigned DQS_TIMER_W     = 5;
  localparam int unsigned LOCK_CYCLES_DEF = 16;

  localparam logic [TAP_W-1:0]       TAP_MAX        = '1;
  localparam logic [TAP_W-1:0]       TAP_MIN        = '0;
  localparam logic [DQS_TIMER_W-1:0] DQS_TIMER_LAST = '1;

  // ICLK source selection codes; the aliases are legacy encodings.
  localparam logic [3:0] CLK_SRC_PHASE_REF   = 4'b0000;
  localparam logic [3:0] CLK_SRC_PHASE_REF_A = 4'b0001;
  localparam logic [3:0] CLK_SRC_PHASE_REF_B = 4'b0011;
  localparam logic [3:0] CLK_SRC_MEM_REF     = 4'b0010;
  localparam logic [3:0] CLK_SRC_MEM_REF_A   = 4'b0101;
  localparam logic [3:0] CLK_SRC_FREQ_REF    = 4'b1000;

  localparam logic [1:0] FREQ_DIV_NONE = 2'b00;
  localparam logic [1:0] FREQ_DIV_2    = 2'b01;
  localparam logic [1:0] FREQ_DIV_4    = 2'b10;

  typedef enum logic [1:0] {
    DQS_IDLE   = 2'd0,
    DQS_SEARCH = 2'd1,
    DQS_FOUND  = 2'd2,
    DQS_ABORT  = 2'd3
  } dqs_state_e;

  // True when a step in the requested direction would leave the tap range.
  function automatic logic tap_at_limit(input logic [TAP_W-1:0] tap, input logic inc);
    return inc ? (tap == TAP_MAX) : (tap == TAP_MIN);
  endfunction

endpackage

// File: rtl/phaser_in_clkdiv.sv
// ICLK-domain divider producing ICLKDIV, with optional SYNCIN phase restart.
module phaser_in_clkdiv
  import phaser_in_pkg::*;
#(
  parameter int unsigned CLKOUT_DIV      = 4,
  parameter logic        SYNC_IN_DIV_RST = 1'b0
) (
  input  logic iclk_i,
  input  logic rst_i,
  input  logic syncin_i,
  output logic iclkdiv_o
);

  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(CLKOUT_DIV - 1);
  localparam logic [DIV_CNT_W-1:0] CNT_HIGH = DIV_CNT_W'(CLKOUT_DIV / 2);

  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]           sync_q;
  logic                 div_q;
  logic                 restart_c;

  // Edge detect on the sampled SYNCIN; the first stage is the newest sample.
  assign restart_c = SYNC_IN_DIV_RST & sync_q[0] & ~sync_q[1];

  always_comb begin
    cnt_d = cnt_q + DIV_CNT_W'(1);
    if (restart_c || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  // Output is registered from the next count so it is high while count < CLKOUT_DIV/2.
  always_ff @(posedge iclk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sync_q <= 2'b00;
      div_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= {sync_q[0], syncin_i};
      div_q  <= (cnt_d < CNT_HIGH);
    end
  end

  assign iclkdiv_o = div_q;

endmodule

// File: rtl/phaser_in_core.sv
// Input-side DDR phaser: clock select/divide, lock tracking, fine tap,
// stage-2 counter and the DQS-find sequencer.
module phaser_in_core
  import phaser_in_pkg::*;
#(
  parameter int unsigned CLKOUT_DIV      = 4,
  parameter int unsigned FINE_DELAY      = 0,
  parameter logic [3:0]  OUTPUT_CLK_SRC  = 4'b0000,
  parameter logic [1:0]  FREQ_REF_DIV    = 2'b00,
  parameter logic        BURST_MODE      = 1'b0,
  parameter logic        SYNC_IN_DIV_RST = 1'b0,
  parameter int unsigned LOCK_CYCLES     = LOCK_CYCLES_DEF
) (
  input  logic             SYSCLK,
  input  logic             RSTDQSFIND,
  input  logic             RST,
  input  logic             FREQREFCLK,
  input  logic             MEMREFCLK,
  input  logic             PHASEREFCLK,
  input  logic             SYNCIN,
  input  logic             FINEENABLE,
  input  logic             FINEINC,
  input  logic             COUNTERLOADEN,
  input  logic [CNT_W-1:0] COUNTERLOADVAL,
  input  logic             COUNTERREADEN,
  input  logic [1:0]       ENCALIBPHY,
  input  logic [1:0]       RANKSELPHY,
  input  logic             BURSTPENDINGPHY,
  output logic             ICLK,
  output logic             ICLKDIV,
  output logic             RCLK,
  output logic             PHASELOCKED,
  output logic             ISERDESRST,
  output logic             WRENABLE,
  output logic             FINEOVERFLOW,
  output logic [CNT_W-1:0] COUNTERREADVAL,
  output logic             DQSFOUND,
  output logic             DQSOUTOFRANGE
);

  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

  // ---------------- clock path ----------------
  logic freq_div2_q, freq_div4_q;
  logic freq_ref_c, iclk_c, iclkdiv_c;

  always_ff @(posedge FREQREFCLK or posedge RST) begin
    if (RST) freq_div2_q <= 1'b0;
    else     freq_div2_q <= ~freq_div2_q;
  end

  always_ff @(posedge freq_div2_q or posedge RST) begin
    if (RST) freq_div4_q <= 1'b0;
    else     freq_div4_q <= ~freq_div4_q;
  end

  always_comb begin
    freq_ref_c = FREQREFCLK;
    case (FREQ_REF_DIV)
      FREQ_DIV_NONE: freq_ref_c = FREQREFCLK;
      FREQ_DIV_2:    freq_ref_c = freq_div2_q;
      FREQ_DIV_4:    freq_ref_c = freq_div4_q;
      default:       freq_ref_c = FREQREFCLK;
    endcase
  end

  // Unlisted source codes fall back to the phase reference.
  always_comb begin
    iclk_c = PHASEREFCLK;
    case (OUTPUT_CLK_SRC)
      CLK_SRC_PHASE_REF, CLK_SRC_PHASE_REF_A, CLK_SRC_PHASE_REF_B: iclk_c = PHASEREFCLK;
      CLK_SRC_MEM_REF, CLK_SRC_MEM_REF_A:                          iclk_c = MEMREFCLK;
      CLK_SRC_FREQ_REF:                                            iclk_c = freq_ref_c;
      default:                                                     iclk_c = PHASEREFCLK;
    endcase
  end

  phaser_in_clkdiv #(
    .CLKOUT_DIV      (CLKOUT_DIV),
    .SYNC_IN_DIV_RST (SYNC_IN_DIV_RST)
  ) u_clkdiv (
    .iclk_i    (iclk_c),
    .rst_i     (RST),
    .syncin_i  (SYNCIN),
    .iclkdiv_o (iclkdiv_c)
  );

  // ---------------- lock tracking ----------------
  logic [LOCK_W-1:0] lock_cnt_q;
  logic              locked_q;

  always_ff @(posedge PHASEREFCLK or posedge RST) begin
    if (RST) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else if (!locked_q) begin
      lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
      if (lock_cnt_q == LOCK_W'(LOCK_CYCLES - 1)) begin
        locked_q <= 1'b1;
      end
    end
  end

  // ISERDES reset drops on the second ICLKDIV edge that sees lock.
  logic lock_seen_q, iserdes_rst_q, wr_en_q;

  always_ff @(posedge iclkdiv_c or posedge RST) begin
    if (RST) begin
      lock_seen_q   <= 1'b0;
      iserdes_rst_q <= 1'b1;
      wr_en_q       <= 1'b0;
    end else begin
      lock_seen_q   <= locked_q;
      iserdes_rst_q <= ~lock_seen_q;
      wr_en_q       <= locked_q & (BURST_MODE ? BURSTPENDINGPHY : 1'b1);
    end
  end

  // ---------------- SYSCLK control: fine tap and stage-2 counter ----------------
  logic [TAP_W-1:0] fine_tap_q, fine_tap_d;
  logic             fine_ovf_q, fine_ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] read_val_q, read_val_d;
  logic [1:0]       rank_q;
  logic             rank_unused_c;

  always_comb begin
    fine_tap_d = fine_tap_q;
    fine_ovf_d = 1'b0;
    if (FINEENABLE) begin
      if (tap_at_limit(fine_tap_q, FINEINC)) begin
        fine_ovf_d = 1'b1;
      end else if (FINEINC) begin
        fine_tap_d = fine_tap_q + TAP_W'(1);
      end else begin
        fine_tap_d = fine_tap_q - TAP_W'(1);
      end
    end
  end

  // A same-cycle read returns the value held before the load.
  always_comb begin
    cnt_d      = COUNTERLOADEN ? COUNTERLOADVAL : cnt_q;
    read_val_d = COUNTERREADEN ? cnt_q : read_val_q;
  end

  always_ff @(posedge SYSCLK or negedge RSTDQSFIND) begin
    if (!RSTDQSFIND) begin
      fine_tap_q <= TAP_W'(FINE_DELAY);
      fine_ovf_q <= 1'b0;
      cnt_q      <= '0;
      read_val_q <= '0;
      rank_q     <= 2'b00;
    end else begin
      fine_tap_q <= fine_tap_d;
      fine_ovf_q <= fine_ovf_d;
      cnt_q      <= cnt_d;
      read_val_q <= read_val_d;
      rank_q     <= RANKSELPHY;
    end
  end

  // Rank is held for the PHY but not consumed inside this core.
  assign rank_unused_c = ^rank_q;

  // ---------------- DQS-find sequencer ----------------
  dqs_state_e             state_q, state_d;
  logic [DQS_TIMER_W-1:0] timer_q, timer_d;
  logic                   dqs_found_q;

  always_ff @(posedge SYSCLK or negedge RSTDQSFIND) begin
    if (!RSTDQSFIND) begin
      state_q     <= DQS_IDLE;
      timer_q     <= '0;
      dqs_found_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      dqs_found_q <= (state_d == DQS_FOUND);
    end
  end

  // FOUND and ABORT are terminal until RSTDQSFIND.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      DQS_IDLE: begin
        if (ENCALIBPHY != 2'b00) begin
          state_d = DQS_SEARCH;
          timer_d = '0;
        end
      end
      DQS_SEARCH: begin
        if (ENCALIBPHY == 2'b00) begin
          state_d = DQS_ABORT;
        end else begin
          timer_d = timer_q + DQS_TIMER_W'(1);
          if (timer_d == DQS_TIMER_LAST) begin
            state_d = DQS_FOUND;
          end
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // ---------------- outputs ----------------
  assign ICLK           = iclk_c;
  assign ICLKDIV        = iclkdiv_c;
  assign RCLK           = iclkdiv_c;
  assign PHASELOCKED    = locked_q;
  assign ISERDESRST     = iserdes_rst_q;
  assign WRENABLE       = wr_en_q;
  assign FINEOVERFLOW   = fine_ovf_q;
  assign COUNTERREADVAL = read_val_q;
  assign DQSFOUND       = dqs_found_q;
  assign DQSOUTOFRANGE  = RST | (state_q == DQS_ABORT);

endmodule

// File: tb/tb_phaser_in_core.sv
// Self-checking bench for phaser_in_core: vector table, randomized SYSCLK
// traffic against a reference model, and clock-path sequences.
module tb_phaser_in_core;

  logic       SYSCLK = 1'b0, PHASEREFCLK = 1'b0, MEMREFCLK = 1'b0, FREQREFCLK = 1'b0;
  logic       RSTDQSFIND, RST, SYNCIN;
  logic       FINEENABLE, FINEINC, COUNTERLOADEN, COUNTERREADEN, BURSTPENDINGPHY;
  logic [5:0] COUNTERLOADVAL;
  logic [1:0] ENCALIBPHY, RANKSELPHY;
  logic       ICLK, ICLKDIV, RCLK, PHASELOCKED, ISERDESRST, WRENABLE, FINEOVERFLOW;
  logic       DQSFOUND, DQSOUTOFRANGE;
  logic [5:0] COUNTERREADVAL;

  logic       f_iclk, f_unused_div, f_unused_rclk, f_unused_lock, f_unused_isr;
  logic       f_unused_wr, f_unused_ovf, f_unused_found, f_unused_oor;
  logic [5:0] f_unused_rv;

  int n_tests = 0;
  int n_fail  = 0;
  int f_edges = 0;

  always #5 SYSCLK      = ~SYSCLK;
  always #4 PHASEREFCLK = ~PHASEREFCLK;
  always #6 MEMREFCLK   = ~MEMREFCLK;
  always #3 FREQREFCLK  = ~FREQREFCLK;

  phaser_in_core #(
    .CLKOUT_DIV(5), .FINE_DELAY(62), .OUTPUT_CLK_SRC(4'b0000), .FREQ_REF_DIV(2'b00),
    .BURST_MODE(1'b1), .SYNC_IN_DIV_RST(1'b1), .LOCK_CYCLES(16)
  ) u_dut (
    .SYSCLK(SYSCLK), .RSTDQSFIND(RSTDQSFIND), .RST(RST), .FREQREFCLK(FREQREFCLK),
    .MEMREFCLK(MEMREFCLK), .PHASEREFCLK(PHASEREFCLK), .SYNCIN(SYNCIN),
    .FINEENABLE(FINEENABLE), .FINEINC(FINEINC), .COUNTERLOADEN(COUNTERLOADEN),
    .COUNTERLOADVAL(COUNTERLOADVAL), .COUNTERREADEN(COUNTERREADEN),
    .ENCALIBPHY(ENCALIBPHY), .RANKSELPHY(RANKSELPHY), .BURSTPENDINGPHY(BURSTPENDINGPHY),
    .ICLK(ICLK), .ICLKDIV(ICLKDIV), .RCLK(RCLK), .PHASELOCKED(PHASELOCKED),
    .ISERDESRST(ISERDESRST), .WRENABLE(WRENABLE), .FINEOVERFLOW(FINEOVERFLOW),
    .COUNTERREADVAL(COUNTERREADVAL), .DQSFOUND(DQSFOUND), .DQSOUTOFRANGE(DQSOUTOFRANGE)
  );

  // Second instance exercises the FREQ_REF source with the /4 predivider.
  phaser_in_core #(
    .CLKOUT_DIV(4), .FINE_DELAY(0), .OUTPUT_CLK_SRC(4'b1000), .FREQ_REF_DIV(2'b10),
    .BURST_MODE(1'b0), .SYNC_IN_DIV_RST(1'b0), .LOCK_CYCLES(16)
  ) u_dut_f (
    .SYSCLK(SYSCLK), .RSTDQSFIND(RSTDQSFIND), .RST(RST), .FREQREFCLK(FREQREFCLK),
    .MEMREFCLK(MEMREFCLK), .PHASEREFCLK(PHASEREFCLK), .SYNCIN(SYNCIN),
    .FINEENABLE(FINEENABLE), .FINEINC(FINEINC), .COUNTERLOADEN(COUNTERLOADEN),
    .COUNTERLOADVAL(COUNTERLOADVAL), .COUNTERREADEN(COUNTERREADEN),
    .ENCALIBPHY(ENCALIBPHY), .RANKSELPHY(RANKSELPHY), .BURSTPENDINGPHY(BURSTPENDINGPHY),
    .ICLK(f_iclk), .ICLKDIV(f_unused_div), .RCLK(f_unused_rclk), .PHASELOCKED(f_unused_lock),
    .ISERDESRST(f_unused_isr), .WRENABLE(f_unused_wr), .FINEOVERFLOW(f_unused_ovf),
    .COUNTERREADVAL(f_unused_rv), .DQSFOUND(f_unused_found), .DQSOUTOFRANGE(f_unused_oor)
  );

  always @(posedge f_iclk) f_edges++;

  typedef struct packed {
    logic       fen;
    logic       finc;
    logic       ld;
    logic [5:0] ldval;
    logic       rd;
    logic       exp_ovf;
    logic [5:0] exp_rv;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic sys_step();
    @(posedge SYSCLK);
    @(negedge SYSCLK);
  endtask

  task automatic dqs_reset();
    @(negedge SYSCLK);
    RSTDQSFIND = 1'b0;
    @(negedge SYSCLK);
    RSTDQSFIND = 1'b1;
  endtask

  task automatic idle_inputs();
    FINEENABLE = 1'b0; FINEINC = 1'b0; COUNTERLOADEN = 1'b0;
    COUNTERLOADVAL = 6'h00; COUNTERREADEN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   tap_m, cnt_m, rv_m, rises_after_lock, e0;
    logic ovf_m, fen, finc, ld, rd, prev_div, div_exp, lock_exp, wr_exp, burst_at_edge;
    logic [5:0] ldv;

    // {fen, finc, ld, ldval, rd, exp_ovf, exp_rv}; tap starts at 62
    vecs[0] = '{1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00}; // 62 -> 63
    vecs[1] = '{1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 6'h00}; // held at 63, overflow
    vecs[2] = '{1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00}; // overflow lasts one cycle
    vecs[3] = '{1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00}; // 63 -> 62
    vecs[4] = '{1'b0, 1'b0, 1'b1, 6'h2A, 1'b0, 1'b0, 6'h00}; // load 2A
    vecs[5] = '{1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 6'h2A}; // read 2A
    vecs[6] = '{1'b0, 1'b0, 1'b1, 6'h15, 1'b1, 1'b0, 6'h2A}; // load+read returns old
    vecs[7] = '{1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 6'h15}; // new value visible
    vecs[8] = '{1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 6'h15}; // read value holds

    RST = 1'b1; RSTDQSFIND = 1'b0; SYNCIN = 1'b0; ENCALIBPHY = 2'b00;
    RANKSELPHY = 2'b10; BURSTPENDINGPHY = 1'b0;
    idle_inputs();
    repeat (3) @(negedge SYSCLK);

    chk("rst_readval", COUNTERREADVAL, 6'h00);
    chk("rst_fineovf", FINEOVERFLOW, 1'b0);
    chk("rst_dqsfound", DQSFOUND, 1'b0);
    chk("rst_outofrange", DQSOUTOFRANGE, 1'b1);
    chk("rst_locked", PHASELOCKED, 1'b0);
    chk("rst_iserdesrst", ISERDESRST, 1'b1);
    chk("rst_wrenable", WRENABLE, 1'b0);
    chk("rst_iclkdiv", ICLKDIV, 1'b0);

    @(negedge SYSCLK);
    RSTDQSFIND = 1'b1;

    // Table-driven fine tap and counter vectors.
    for (int i = 0; i < 9; i++) begin
      FINEENABLE = vecs[i].fen; FINEINC = vecs[i].finc; COUNTERLOADEN = vecs[i].ld;
      COUNTERLOADVAL = vecs[i].ldval; COUNTERREADEN = vecs[i].rd;
      sys_step();
      chk($sformatf("vec%0d_ovf", i), FINEOVERFLOW, vecs[i].exp_ovf);
      chk($sformatf("vec%0d_readval", i), COUNTERREADVAL, vecs[i].exp_rv);
    end
    idle_inputs();

    // Randomized fine tap / counter traffic: up-biased then down-biased.
    dqs_reset();
    tap_m = 62; cnt_m = 0; rv_m = 0;
    for (int i = 0; i < 600; i++) begin
      fen  = ($urandom_range(0, 3) != 0);
      finc = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      ld   = ($urandom_range(0, 3) == 0);
      ldv  = 6'($urandom_range(0, 63));
      rd   = ($urandom_range(0, 1) == 1);
      FINEENABLE = fen; FINEINC = finc; COUNTERLOADEN = ld; COUNTERLOADVAL = ldv;
      COUNTERREADEN = rd;
      ovf_m = 1'b0;
      if (fen) begin
        if (finc) begin
          if (tap_m == 63) ovf_m = 1'b1; else tap_m = tap_m + 1;
        end else begin
          if (tap_m == 0) ovf_m = 1'b1; else tap_m = tap_m - 1;
        end
      end
      if (rd) rv_m = cnt_m;
      if (ld) cnt_m = int'(ldv);
      sys_step();
      chk($sformatf("rand%0d_ovf", i), FINEOVERFLOW, ovf_m);
      chk($sformatf("rand%0d_readval", i), COUNTERREADVAL, rv_m);
    end
    idle_inputs();

    // Clock path: release RST, restart divider phase with SYNCIN after edge 2.
    @(negedge PHASEREFCLK);
    chk("iclk_low", ICLK, 1'b0);
    RST = 1'b0;
    prev_div = 1'b0; rises_after_lock = 0; wr_exp = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      burst_at_edge = BURSTPENDINGPHY;
      @(posedge PHASEREFCLK);
      #1;
      if (n == 1) chk("iclk_high", ICLK, 1'b1);
      @(negedge PHASEREFCLK);
      // Before the restart (edge 3) the divider runs from reset; after it, period 5 high 2.
      div_exp  = (n < 3) ? (n == 1) : (((n - 3) % 5) < 2);
      lock_exp = (n >= 16);
      if (div_exp && !prev_div) begin
        if (lock_exp) rises_after_lock++;
        wr_exp = lock_exp & burst_at_edge;
      end
      chk($sformatf("edge%0d_iclkdiv", n), ICLKDIV, div_exp);
      chk($sformatf("edge%0d_rclk", n), RCLK, div_exp);
      chk($sformatf("edge%0d_locked", n), PHASELOCKED, lock_exp);
      chk($sformatf("edge%0d_iserdesrst", n), ISERDESRST, (rises_after_lock < 2));
      chk($sformatf("edge%0d_wrenable", n), WRENABLE, wr_exp);
      prev_div = div_exp;
      SYNCIN = (n == 1);
      BURSTPENDINGPHY = (n >= 14) ? ($urandom_range(0, 1) == 1) : 1'b0;
    end

    // FREQ_REF /4: exactly one ICLK rise per four FREQREFCLK rises.
    @(negedge FREQREFCLK);
    e0 = f_edges;
    repeat (40) @(posedge FREQREFCLK);
    #1;
    chk("freqref_div4_edges", f_edges - e0, 10);

    // DQS find completes after 32 SYSCLK cycles with calibration held.
    dqs_reset();
    ENCALIBPHY = 2'b01;
    for (int k = 1; k <= 32; k++) begin
      sys_step();
      chk($sformatf("dqs_search%0d_found", k), DQSFOUND, (k >= 32));
      chk($sformatf("dqs_search%0d_oor", k), DQSOUTOFRANGE, 1'b0);
    end
    ENCALIBPHY = 2'b00;
    repeat (3) sys_step();
    chk("dqs_found_sticky", DQSFOUND, 1'b1);
    chk("dqs_found_oor", DQSOUTOFRANGE, 1'b0);

    // Dropping calibration after 10 cycles aborts; abort is terminal.
    dqs_reset();
    ENCALIBPHY = 2'b01;
    repeat (10) sys_step();
    chk("dqs_pre_abort_oor", DQSOUTOFRANGE, 1'b0);
    ENCALIBPHY = 2'b00;
    sys_step();
    chk("dqs_abort_oor", DQSOUTOFRANGE, 1'b1);
    chk("dqs_abort_found", DQSFOUND, 1'b0);
    ENCALIBPHY = 2'b11;
    repeat (40) sys_step();
    chk("dqs_abort_hold_oor", DQSOUTOFRANGE, 1'b1);
    chk("dqs_abort_hold_found", DQSFOUND, 1'b0);

    // Re-asserting RST drops lock and flags out-of-range immediately.
    ENCALIBPHY = 2'b00;
    dqs_reset();
    sys_step();
    chk("idle_oor", DQSOUTOFRANGE, 1'b0);
    chk("pre_rst_locked", PHASELOCKED, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    chk("rerst_locked", PHASELOCKED, 1'b0);
    chk("rerst_oor", DQSOUTOFRANGE, 1'b1);
    chk("rerst_iserdesrst", ISERDESRST, 1'b1);
    chk("rerst_iclkdiv", ICLKDIV, 1'b0);
    chk("rerst_wrenable", WRENABLE, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
